// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC stepping and the fetch packet
// handed from fetch to decode.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch packets. Flush empties it in one cycle and
// wins over any write or read in that cycle. The head is read straight from
// storage registers, so rd_data has no combinational path from any input.
// Handshake: a write is taken on a rising edge when wr_en is high and there
// is room (or a read frees a slot in the same cycle); a read is taken when
// rd_en is high and the FIFO is not empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic          rd_en,
    input  fetch_pkt_t    wr_data,
    output fetch_pkt_t    rd_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_pkt_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_rd;
    logic w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign w_do_rd = rd_en && !empty && !flush;
    assign w_do_wr = wr_en && (!full || w_do_rd) && !flush;
    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Storage: cleared on reset, written at the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule : fetch_fifo

// File: rtl/ifetch.sv
// Instruction fetch stage. Owns the PC, reads the combinational ROM at the PC
// and pushes {pc, inst} into a small FIFO feeding decode. A redirect from
// execute flushes the FIFO and reloads the PC, overriding everything else.
// Output handshake: a head is transferred on a rising edge when out_valid and
// out_ready are both high and no redirect is present in that cycle; out_*
// stay stable while out_valid is high and out_ready is low.
// dbg_count exposes the FIFO occupancy for observation.
module ifetch
    import cpu_pkg::*;
#(
    parameter  logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter  int              DEPTH    = 2,
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [XLEN-1:0]   imem_adr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CW-1:0]     dbg_count
);

    logic [XLEN-1:0] r_pc;

    logic            w_deq;
    logic            w_enq;
    logic            w_full;
    logic            w_empty;
    logic [XLEN-1:0] w_redirect_target;
    fetch_pkt_t      w_wr_pkt;
    fetch_pkt_t      w_head;

    // Redirect targets are forced word-aligned by clearing the low two bits.
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // A redirect cancels both the dequeue and the enqueue of its cycle.
    assign w_deq = !w_empty && out_ready && !redirect_valid;
    assign w_enq = !redirect_valid && (!w_full || w_deq);

    assign w_wr_pkt.pc   = r_pc;
    assign w_wr_pkt.inst = imem_inst;

    assign imem_adr  = r_pc;
    assign out_valid = !w_empty;
    assign out_pc    = w_head.pc;
    assign out_inst  = w_head.inst;

    // PC: reload on redirect, step by one word whenever an instruction is enqueued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_enq) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr_en   (w_enq),
        .rd_en   (w_deq),
        .wr_data (w_wr_pkt),
        .rd_data (w_head),
        .count   (dbg_count),
        .empty   (w_empty),
        .full    (w_full)
    );

endmodule : ifetch

// File: tb/tb_ifetch.sv
// Bench for ifetch. The driver keeps a queue-based model of the fetch stage
// (next fetch address plus a bounded list of pending {pc, inst}) and, every
// cycle, pushes the outputs the DUT must show into exp_q; a monitor on the
// falling edge pops and compares them.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          W        = 1 + 32 + 32 + 32 + 8;

    logic        clk;
    logic        rst;
    logic [31:0] imem_adr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  dbg_count;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  exp_q [$];
    logic [63:0]   m_fifo [$];
    logic [31:0]   m_pc;

    ifetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_adr       (imem_adr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .dbg_count      (dbg_count)
    );

    // ROM contents: a fixed scramble of the address, nonzero at address 0.
    function automatic logic [31:0] rom_word(input logic [31:0] adr);
        return adr ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_inst = rom_word(imem_adr);

    // Clock / reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge given this cycle's inputs.
    task automatic model_step(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic deq;
        logic room;
        if (redir) begin
            m_fifo.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            deq  = (m_fifo.size() > 0) && rdy;
            room = (m_fifo.size() < DEPTH) || deq;
            if (deq) void'(m_fifo.pop_front());
            if (room) begin
                m_fifo.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Called just after a rising edge: record expected outputs, drive inputs, advance model.
    task automatic drive_cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic [63:0] head;
        logic        vld;
        head = '0;
        vld  = (m_fifo.size() != 0);
        if (vld) head = m_fifo[0];
        exp_q.push_back({vld, head[63:32], head[31:0], m_pc, 8'(m_fifo.size())});
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        model_step(rdy, redir, tgt);
    endtask

    task automatic run(input int n, input logic rdy);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_cycle(rdy, 1'b0, 32'h0);
        end
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        drive_cycle(rdy, 1'b1, tgt);
    endtask

    // Asserts reset away from any edge, checks the immediate effect, releases
    // it after the next edge and drives the first post-reset cycle.
    task automatic apply_reset(input logic rdy);
        rst = 1'b1;
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_imem_adr", imem_adr, RESET_PC);
        m_fifo.delete();
        m_pc = RESET_PC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_cycle(rdy, 1'b0, 32'h0);
    endtask

    // Monitor: compare the DUT against the expected record for this cycle.
    logic [W-1:0] mon_rec;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_rec = exp_q.pop_front();
            check("out_valid", {31'h0, out_valid}, {31'h0, mon_rec[W-1]});
            check("imem_adr", imem_adr, mon_rec[39:8]);
            check("count", {30'h0, dbg_count}, {24'h0, mon_rec[7:0]});
            if (mon_rec[W-1]) begin
                check("out_pc", out_pc, mon_rec[103:72]);
                check("out_inst", out_inst, mon_rec[71:40]);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        m_pc           = RESET_PC;

        // Streaming from reset with decode always ready.
        apply_reset(1'b1);
        run(8, 1'b1);

        // Stall from reset: FIFO fills to 2, PC holds, then drains without a bubble.
        @(posedge clk);
        #6;
        apply_reset(1'b0);
        run(5, 1'b0);
        run(6, 1'b1);

        // Redirect while full and ready: the offered head is dropped.
        run(3, 1'b0);
        redirect_to(32'h0000_0040, 1'b1);
        run(4, 1'b1);

        // Misaligned target is forced to a word boundary.
        redirect_to(32'h0000_0043, 1'b1);
        run(3, 1'b1);

        // PC wraps past the top of the address space.
        redirect_to(32'hFFFF_FFF8, 1'b1);
        run(5, 1'b1);

        // Asynchronous reset with two entries held.
        run(3, 1'b0);
        #5;
        apply_reset(1'b1);
        run(5, 1'b1);

        // Randomized mix of stalls and redirects.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 9) == 0) begin
                drive_cycle($urandom_range(0, 3) != 0, 1'b1,
                            ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom);
            end else begin
                drive_cycle($urandom_range(0, 3) != 0, 1'b0, 32'h0);
            end
        end

        repeat (2) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ifetch
